pipe_stage_ctl: RTL
===================

Name: pipe_stage_ctl

Overview:
- Consumer of the hazard unit's NOP outputs.
- Owns the four pipeline boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB) for valid bits, PC/instruction and control bundles.
- Converts fd_nop/de_nop/em_nop/mw_nop into per-stage bubble, hold and PC-write actions.
- Runs the halt-drain state machine and a saturating stall counter.

Parameters:
- INSTR_W, 16, instruction and PC width.
- CTRL_W, 16, width of the decoded control bundle carried ID→EX→MEM→WB.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_instr  in  INSTR_W  fetched instruction.
- if_pc  in  INSTR_W  PC+2 of the fetched instruction.
- id_ctrl  in  CTRL_W  control bundle decoded from id_instr.
- id_halt  in  1  decoder flags id_instr as HALT.
- fd_nop  in  1  load a bubble into IF/ID (branch/jump flush, createdump stall).
- de_nop  in  1  load a bubble into ID/EX; hold IF/ID and PC.
- em_nop  in  1  load a bubble into EX/MEM; hold ID/EX, IF/ID and PC.
- mw_nop  in  1  load a bubble into MEM/WB; hold EX/MEM, ID/EX, IF/ID and PC.
- id_instr, id_pc  out  INSTR_W  IF/ID contents.
- id_valid  out  1  IF/ID holds a real instruction.
- ex_ctrl  out  CTRL_W  ID/EX control bundle.
- ex_valid  out  1  ID/EX holds a real instruction.
- mem_ctrl  out  CTRL_W  EX/MEM control bundle.
- mem_valid  out  1  EX/MEM holds a real instruction.
- wb_ctrl  out  CTRL_W  MEM/WB control bundle.
- wb_valid  out  1  MEM/WB holds a real instruction.
- pc_write  out  1  PC may update this cycle (combinational).
- halted  out  1  processor halted (registered).
- stall_cnt  out  CNT_W  cycles in which pc_write was 0 while in RUN.

Behaviour:
- Reset (registered on rst at the clk edge):
  - All *_valid = 0, all ctrl/instr/pc registers = 0.
  - Per-stage halt flags = 0, state = RUN, halted = 0, stall_cnt = 0.
- A bubble is valid = 0 with ctrl = 0. A bubble never drives RegWrite/MemWrite downstream.
- Hold priority: the most downstream asserted nop wins.
  - Stages upstream of it hold their contents.
  - Its own stage loads a bubble.
  - Stages downstream of it advance normally.
- Example: em_nop & de_nop together → EX/MEM bubble; ID/EX holds (de_nop is ignored); IF/ID holds.
- fd_nop only takes effect when IF/ID is not held. If IF/ID is held, it holds and the flush is ignored; the hazard unit re-asserts fd_nop next cycle.
- pc_write = 0 when any of de_nop, em_nop, mw_nop is asserted, or when state ≠ RUN. Otherwise pc_write = 1; fd_nop alone does not block PC (the redirect proceeds).
- Latency: an instruction with no nops passes IF/ID→MEM/WB in 3 cycles after its IF/ID load.
- Halt flag handling:
  - Each of ID/EX, EX/MEM and MEM/WB carries a 1-bit halt flag alongside valid.
  - ID/EX halt = id_halt & id_valid, captured when ID/EX loads a non-bubble.
- State machine:
  - RUN: when ID/EX captures a valid halt → DRAIN.
  - DRAIN: pc_write = 0; IF/ID loads bubbles every cycle regardless of fd_nop; nops still apply downstream. When MEM/WB captures a valid halt → HALTED.
  - HALTED: halted = 1 from the cycle after the transition; all stage registers hold; pc_write = 0. Exit only via rst.
- A flush (fd_nop) never removes a halt already in ID/EX or beyond.
- rst mid-DRAIN or in HALTED returns to the reset state next edge.
- stall_cnt:
  - Increments on each RUN cycle with pc_write = 0.
  - Saturates at all-ones.
  - Frozen in DRAIN and HALTED.

Test Plan:
- Free flow: 4 back-to-back valid instructions, no nops → each instruction's ctrl appears on wb_ctrl exactly 3 cycles after its ID load; stall_cnt stays 0; pc_write = 1 throughout.
- Load-use: de_nop for 1 cycle with instr A in IF/ID → ex_valid = 0 next cycle; id_instr still A; pc_write = 0 that cycle; stall_cnt = 1.
- Branch flush: fd_nop 1 cycle with no other nop → id_valid = 0 next cycle; pc_write = 1; stall_cnt unchanged.
- Priority: mw_nop & em_nop & fd_nop in the same cycle → wb_valid = 0; EX/MEM, ID/EX and IF/ID unchanged (IF/ID still valid); pc_write = 0.
- Halt drain: HALT followed by 2 instructions → after HALT enters ID/EX, id_valid = 0 every cycle and pc_write = 0; halted = 1 one cycle after HALT reaches MEM/WB; registers frozen for 10 more cycles.
- Reset/saturation:
  - rst asserted in HALTED → next cycle halted = 0, all valids 0, stall_cnt = 0.
  - Separately, hold de_nop for 70000 cycles with CNT_W = 16 → stall_cnt = 16'hFFFF.

Source files
------------

// File: rtl/pipe_stage_if.sv
`default_nettype none
// =============================================================================
// Module   : pipe_stage_if
// Brief    : Handshake bundle between hazard/decode logic and pipe_stage_ctl.
// Revision : 1.0 - initial release
// =============================================================================
interface pipe_stage_if #(
    parameter int INSTR_W = 16,
    parameter int CTRL_W  = 16,
    parameter int CNT_W   = 16
) ();
    logic [INSTR_W-1:0] if_instr;
    logic [INSTR_W-1:0] if_pc;
    logic [CTRL_W-1:0]  id_ctrl;
    logic               id_halt;
    logic               fd_nop;
    logic               de_nop;
    logic               em_nop;
    logic               mw_nop;

    logic [INSTR_W-1:0] id_instr;
    logic [INSTR_W-1:0] id_pc;
    logic               id_valid;
    logic [CTRL_W-1:0]  ex_ctrl;
    logic               ex_valid;
    logic [CTRL_W-1:0]  mem_ctrl;
    logic               mem_valid;
    logic [CTRL_W-1:0]  wb_ctrl;
    logic               wb_valid;
    logic               pc_write;
    logic               halted;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output if_instr, if_pc, id_ctrl, id_halt, fd_nop, de_nop, em_nop, mw_nop,
        input  id_instr, id_pc, id_valid, ex_ctrl, ex_valid, mem_ctrl, mem_valid,
               wb_ctrl, wb_valid, pc_write, halted, stall_cnt
    );

    modport slave (
        input  if_instr, if_pc, id_ctrl, id_halt, fd_nop, de_nop, em_nop, mw_nop,
        output id_instr, id_pc, id_valid, ex_ctrl, ex_valid, mem_ctrl, mem_valid,
               wb_ctrl, wb_valid, pc_write, halted, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_ctl.sv
`default_nettype none
// =============================================================================
// Module   : pipe_stage_ctl
// Brief    : Pipeline boundary registers, nop-driven bubble/hold, halt drain.
// Revision : 1.0 - initial release
// =============================================================================
module pipe_stage_ctl #(
    parameter int INSTR_W = 16,
    parameter int CTRL_W  = 16,
    parameter int CNT_W   = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_stage_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d, id_pc_q, id_pc_d;
    logic               id_valid_q, id_valid_d;
    logic [CTRL_W-1:0]  ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
    logic               ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
    logic               ex_halt_q, ex_halt_d, mem_halt_q, mem_halt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic w_frozen, w_wb_load, w_mem_load, w_ex_load, w_id_load, w_id_bubble;
    logic w_halt_capture, w_halt_retire, w_pc_write;

    always_comb begin
        // A stage loads (bubble or data) only when no more-downstream nop holds it.
        w_frozen       = (state_q == ST_HALTED);
        w_wb_load      = !w_frozen;
        w_mem_load     = w_wb_load && !bus.mw_nop;
        w_ex_load      = w_mem_load && !bus.em_nop;
        w_halt_capture = (state_q == ST_RUN) && w_ex_load && !bus.de_nop
                         && id_valid_q && bus.id_halt;
        w_id_load      = (w_ex_load && !bus.de_nop) || (state_q == ST_DRAIN);
        w_id_bubble    = bus.fd_nop || (state_q == ST_DRAIN) || w_halt_capture;
        w_halt_retire  = w_wb_load && !bus.mw_nop && mem_valid_q && mem_halt_q;
        w_pc_write     = (state_q == ST_RUN) && !(bus.de_nop || bus.em_nop || bus.mw_nop);

        state_d     = state_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        id_valid_d  = id_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_valid_d  = ex_valid_q;
        ex_halt_d   = ex_halt_q;
        mem_ctrl_d  = mem_ctrl_q;
        mem_valid_d = mem_valid_q;
        mem_halt_d  = mem_halt_q;
        wb_ctrl_d   = wb_ctrl_q;
        wb_valid_d  = wb_valid_q;
        stall_cnt_d = stall_cnt_q;

        if (w_wb_load) begin
            wb_valid_d = bus.mw_nop ? 1'b0 : mem_valid_q;
            wb_ctrl_d  = bus.mw_nop ? '0   : mem_ctrl_q;
        end
        if (w_mem_load) begin
            mem_valid_d = bus.em_nop ? 1'b0 : ex_valid_q;
            mem_ctrl_d  = bus.em_nop ? '0   : ex_ctrl_q;
            mem_halt_d  = bus.em_nop ? 1'b0 : ex_halt_q;
        end
        if (w_ex_load) begin
            ex_valid_d = !bus.de_nop && id_valid_q;
            ex_ctrl_d  = (!bus.de_nop && id_valid_q) ? bus.id_ctrl : '0;
            ex_halt_d  = !bus.de_nop && id_valid_q && bus.id_halt;
        end
        // Instructions fetched behind a HALT are discarded as they reach IF/ID.
        if (w_id_load) begin
            id_valid_d = !w_id_bubble;
            id_instr_d = w_id_bubble ? '0 : bus.if_instr;
            id_pc_d    = w_id_bubble ? '0 : bus.if_pc;
        end

        case (state_q)
            ST_RUN:    if (w_halt_capture) state_d = ST_DRAIN;
            ST_DRAIN:  if (w_halt_retire)  state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase

        if ((state_q == ST_RUN) && !w_pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            id_instr_q  <= '0;
            id_pc_q     <= '0;
            id_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_valid_q  <= 1'b0;
            ex_halt_q   <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_halt_q  <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            id_valid_q  <= id_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_valid_q  <= ex_valid_d;
            ex_halt_q   <= ex_halt_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_valid_q <= mem_valid_d;
            mem_halt_q  <= mem_halt_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_valid_q  <= wb_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.ex_ctrl   = ex_ctrl_q;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.mem_ctrl  = mem_ctrl_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.wb_ctrl   = wb_ctrl_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.pc_write  = w_pc_write;
    assign bus.halted    = (state_q == ST_HALTED);
    assign bus.stall_cnt = stall_cnt_q;
endmodule
`default_nettype wire
